// File: rtl/dcache_miss_ctrl.sv
// dcache_miss_ctrl: memory-side miss/writeback controller for the data cache.
// A miss with a dirty victim first stores the victim, then loads the missing
// block, fills the array for one cycle and returns the block to the core.
// Only one miss is outstanding at a time.
// Optional feature macro: DCACHE_MISS_STATS_EN adds saturating miss_count and
// wb_count outputs; with the macro undefined those ports do not exist.
module dcache_miss_ctrl #(
    parameter int TAG_W     = 8,
    parameter int IDX_W     = 3,
    parameter int BLOCK_W   = 64,
    parameter int ADDR_W    = 32,
    parameter int MEM_TAG_W = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 req_valid,
    input  logic                 req_write,
    input  logic [TAG_W-1:0]     req_tag,
    input  logic [IDX_W-1:0]     req_index,
    input  logic [BLOCK_W-1:0]   req_data,
    input  logic                 cache_miss,
    input  logic                 victim_dirty,
    input  logic [BLOCK_W-1:0]   victim_data,
    input  logic [TAG_W-1:0]     victim_tag,
    input  logic [IDX_W-1:0]     victim_index,
    output logic                 ctrl_busy,
    output logic [1:0]           mem_command,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [BLOCK_W-1:0]   mem_data,
    input  logic [MEM_TAG_W-1:0] mem_response,
    input  logic [BLOCK_W-1:0]   mem_data_in,
    input  logic [MEM_TAG_W-1:0] mem_tag,
    output logic                 fill_valid,
    output logic [TAG_W-1:0]     fill_tag,
    output logic [IDX_W-1:0]     fill_index,
    output logic [BLOCK_W-1:0]   fill_data,
    output logic                 fill_dirty,
    output logic                 resp_valid,
    output logic [BLOCK_W-1:0]   resp_data
`ifdef DCACHE_MISS_STATS_EN
    ,
    output logic [15:0]          miss_count,
    output logic [15:0]          wb_count
`endif
);

    localparam logic [1:0] CMD_NONE  = 2'd0;
    localparam logic [1:0] CMD_LOAD  = 2'd1;
    localparam logic [1:0] CMD_STORE = 2'd2;
    localparam int         PAD_W     = ADDR_W - TAG_W - IDX_W - 3;

    typedef enum logic [2:0] {
        IDLE,
        WB_REQ,
        FILL_REQ,
        FILL_WAIT,
        FILL_WR
    } state_t;

    state_t state;
    state_t state_next;

    logic                 req_write_q;
    logic [TAG_W-1:0]     req_tag_q;
    logic [IDX_W-1:0]     req_index_q;
    logic [BLOCK_W-1:0]   req_data_q;
    logic [BLOCK_W-1:0]   victim_data_q;
    logic [TAG_W-1:0]     victim_tag_q;
    logic [IDX_W-1:0]     victim_index_q;
    logic [MEM_TAG_W-1:0] pending_q;
    logic [BLOCK_W-1:0]   line_q;

    logic accept_req;
    logic wb_accept;
    logic load_accept;
    logic tag_match;

    // Block-aligned byte address: zero-extended {tag, index} over 8-byte blocks.
    function automatic logic [ADDR_W-1:0] block_addr(input logic [TAG_W-1:0] tag,
                                                     input logic [IDX_W-1:0] index);
        block_addr = {{PAD_W{1'b0}}, tag, index, 3'b000};
    endfunction

    assign accept_req  = (state == IDLE) && req_valid && cache_miss;
    assign wb_accept   = (state == WB_REQ) && (mem_response != '0);
    assign load_accept = (state == FILL_REQ) && (mem_response != '0);
    assign tag_match   = (state == FILL_WAIT) && (mem_tag != '0) && (mem_tag == pending_q);

    assign ctrl_busy = (state != IDLE);

    // State register; reset abandons any miss in flight.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Capture the request and victim at miss start, the memory tag when the load
    // is accepted, and the returned line when its tag comes back.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            req_write_q    <= 1'b0;
            req_tag_q      <= '0;
            req_index_q    <= '0;
            req_data_q     <= '0;
            victim_data_q  <= '0;
            victim_tag_q   <= '0;
            victim_index_q <= '0;
            pending_q      <= '0;
            line_q         <= '0;
        end else begin
            if (accept_req) begin
                req_write_q    <= req_write;
                req_tag_q      <= req_tag;
                req_index_q    <= req_index;
                req_data_q     <= req_data;
                victim_data_q  <= victim_data;
                victim_tag_q   <= victim_tag;
                victim_index_q <= victim_index;
            end
            if (load_accept) begin
                pending_q <= mem_response;
            end
            if (tag_match) begin
                line_q <= mem_data_in;
            end
        end
    end

    // Next-state selection and Moore outputs, all driven from registered state.
    always_comb begin
        state_next  = state;
        mem_command = CMD_NONE;
        mem_addr    = '0;
        mem_data    = '0;
        fill_valid  = 1'b0;
        fill_tag    = '0;
        fill_index  = '0;
        fill_data   = '0;
        fill_dirty  = 1'b0;
        resp_valid  = 1'b0;
        resp_data   = '0;
        case (state)
            IDLE: begin
                if (req_valid && cache_miss) begin
                    state_next = victim_dirty ? WB_REQ : FILL_REQ;
                end
            end
            WB_REQ: begin
                mem_command = CMD_STORE;
                mem_addr    = block_addr(victim_tag_q, victim_index_q);
                mem_data    = victim_data_q;
                if (mem_response != '0) begin
                    state_next = FILL_REQ;
                end
            end
            FILL_REQ: begin
                mem_command = CMD_LOAD;
                mem_addr    = block_addr(req_tag_q, req_index_q);
                if (mem_response != '0) begin
                    state_next = FILL_WAIT;
                end
            end
            FILL_WAIT: begin
                if ((mem_tag != '0) && (mem_tag == pending_q)) begin
                    state_next = FILL_WR;
                end
            end
            FILL_WR: begin
                fill_valid = 1'b1;
                fill_tag   = req_tag_q;
                fill_index = req_index_q;
                fill_data  = req_write_q ? req_data_q : line_q;
                fill_dirty = req_write_q;
                resp_valid = 1'b1;
                resp_data  = line_q;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

`ifdef DCACHE_MISS_STATS_EN
    // Saturating counters of misses started and victim writebacks accepted.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            miss_count <= '0;
            wb_count   <= '0;
        end else begin
            if (accept_req && (miss_count != 16'hFFFF)) begin
                miss_count <= miss_count + 16'd1;
            end
            if (wb_accept && (wb_count != 16'hFFFF)) begin
                wb_count <= wb_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dcache_miss_ctrl.sv
// tb_dcache_miss_ctrl: scoreboard bench for dcache_miss_ctrl. Stimulus pushes
// the expected memory commands and fill/response beats; a negedge monitor pops
// and compares whenever the controller presents them.
module tb_dcache_miss_ctrl;

    logic         clock;
    logic         reset;
    logic         req_valid;
    logic         req_write;
    logic [7:0]   req_tag;
    logic [2:0]   req_index;
    logic [63:0]  req_data;
    logic         cache_miss;
    logic         victim_dirty;
    logic [63:0]  victim_data;
    logic [7:0]   victim_tag;
    logic [2:0]   victim_index;
    logic         ctrl_busy;
    logic [1:0]   mem_command;
    logic [31:0]  mem_addr;
    logic [63:0]  mem_data;
    logic [3:0]   mem_response;
    logic [63:0]  mem_data_in;
    logic [3:0]   mem_tag;
    logic         fill_valid;
    logic [7:0]   fill_tag;
    logic [2:0]   fill_index;
    logic [63:0]  fill_data;
    logic         fill_dirty;
    logic         resp_valid;
    logic [63:0]  resp_data;
`ifdef DCACHE_MISS_STATS_EN
    logic [15:0]  miss_count;
    logic [15:0]  wb_count;
`endif

    // kind: 0 = STORE command, 1 = LOAD command, 2 = fill/response beat
    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [63:0] data;
        logic [7:0]  tag;
        logic [2:0]  idx;
        logic [63:0] fdata;
        logic        dirty;
        logic [63:0] rdata;
    } ev_t;

    ev_t sb[$];
    ev_t mon_e;
    int  checks   = 0;
    int  failures = 0;
    int  exp_miss = 0;
    int  exp_wb   = 0;

    dcache_miss_ctrl dut (
        .clock        (clock),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_write    (req_write),
        .req_tag      (req_tag),
        .req_index    (req_index),
        .req_data     (req_data),
        .cache_miss   (cache_miss),
        .victim_dirty (victim_dirty),
        .victim_data  (victim_data),
        .victim_tag   (victim_tag),
        .victim_index (victim_index),
        .ctrl_busy    (ctrl_busy),
        .mem_command  (mem_command),
        .mem_addr     (mem_addr),
        .mem_data     (mem_data),
        .mem_response (mem_response),
        .mem_data_in  (mem_data_in),
        .mem_tag      (mem_tag),
        .fill_valid   (fill_valid),
        .fill_tag     (fill_tag),
        .fill_index   (fill_index),
        .fill_data    (fill_data),
        .fill_dirty   (fill_dirty),
        .resp_valid   (resp_valid),
        .resp_data    (resp_data)
`ifdef DCACHE_MISS_STATS_EN
        ,
        .miss_count   (miss_count),
        .wb_count     (wb_count)
`endif
    );

    // 10 ns clock
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Hard stop if the bench itself ever stalls
    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] blk_addr(input logic [7:0] tag, input logic [2:0] idx);
        return 32'(tag) * 32'd64 + 32'(idx) * 32'd8;
    endfunction

    function automatic logic [3:0] rand_stray(input logic [3:0] pending);
        logic [3:0] t;
        do begin
            t = 4'($urandom_range(0, 15));
        end while (t == pending);
        return t;
    endfunction

    // Monitor: compare presented commands and fill beats against the scoreboard
    always @(negedge clock) begin
        if (reset === 1'b1) begin
            if (mem_command != 2'd0) begin
                if (sb.size() == 0 || sb[0].kind == 2) begin
                    check_output("mem_cmd_unexpected", 64'(mem_command), 64'd0);
                end else begin
                    mon_e = sb[0];
                    check_output("mem_cmd", 64'(mem_command), (mon_e.kind == 0) ? 64'd2 : 64'd1);
                    check_output("mem_addr", 64'(mem_addr), 64'(mon_e.addr));
                    if (mon_e.kind == 0) begin
                        check_output("mem_data", mem_data, mon_e.data);
                    end
                    if (mem_response != 4'd0) begin
                        void'(sb.pop_front());
                    end
                end
            end else begin
                check_output("idle_mem_addr", 64'(mem_addr), 64'd0);
                check_output("idle_mem_data", mem_data, 64'd0);
            end
            if (fill_valid) begin
                if (sb.size() == 0 || sb[0].kind != 2) begin
                    check_output("fill_unexpected", 64'(fill_valid), 64'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check_output("resp_valid", 64'(resp_valid), 64'd1);
                    check_output("fill_tag", 64'(fill_tag), 64'(mon_e.tag));
                    check_output("fill_index", 64'(fill_index), 64'(mon_e.idx));
                    check_output("fill_data", fill_data, mon_e.fdata);
                    check_output("fill_dirty", 64'(fill_dirty), 64'(mon_e.dirty));
                    check_output("resp_data", resp_data, mon_e.rdata);
                end
            end else begin
                check_output("idle_fill_ctrl", 64'({fill_tag, fill_index, fill_dirty, resp_valid}), 64'd0);
                check_output("idle_fill_data", fill_data, 64'd0);
                check_output("idle_resp_data", resp_data, 64'd0);
            end
        end
    end

    // Wait for a command, hold it off with retries, then accept with resp
    task automatic do_handshake(input logic [1:0] cmd, input int retries, input logic [3:0] resp);
        int waited = 0;
        while (mem_command != cmd && waited < 10) begin
            step();
            waited++;
        end
        check_output("cmd_latency", 64'(waited), 64'd0);
        for (int r = 0; r < retries; r++) begin
            mem_response = 4'd0;
            step();
        end
        mem_response = resp;
        step();
        mem_response = 4'd0;
    endtask

    // One complete miss: model pushes expectations, then stimulus drives it
    task automatic apply_stimulus(input logic [7:0] tag, input logic [2:0] idx, input logic wr,
                                  input logic [63:0] wdata, input logic vd, input logic [7:0] vtag,
                                  input logic [2:0] vidx, input logic [63:0] vdata,
                                  input int wb_retry, input int ld_retry, input logic [3:0] wb_resp,
                                  input logic [3:0] ld_resp, input logic [63:0] line,
                                  input int nstray, input logic [3:0] first_stray, input bit do_reset);
        ev_t e;
        if (vd) begin
            e.kind = 0; e.addr = blk_addr(vtag, vidx); e.data = vdata;
            e.tag = '0; e.idx = '0; e.fdata = '0; e.dirty = 1'b0; e.rdata = '0;
            sb.push_back(e);
            exp_wb++;
        end
        e.kind = 1; e.addr = blk_addr(tag, idx); e.data = '0;
        e.tag = '0; e.idx = '0; e.fdata = '0; e.dirty = 1'b0; e.rdata = '0;
        sb.push_back(e);
        e.kind = 2; e.addr = '0; e.data = '0; e.tag = tag; e.idx = idx;
        e.fdata = wr ? wdata : line; e.dirty = wr; e.rdata = line;
        sb.push_back(e);
        exp_miss++;

        req_valid = 1'b1; cache_miss = 1'b1; req_write = wr; req_tag = tag; req_index = idx;
        req_data = wdata; victim_dirty = vd; victim_tag = vtag; victim_index = vidx; victim_data = vdata;
        step();
        req_valid = 1'b0; cache_miss = 1'($urandom_range(0, 1));
        victim_dirty = 1'($urandom_range(0, 1)); victim_tag = 8'($urandom);
        victim_index = 3'($urandom); victim_data = {$urandom, $urandom}; req_data = {$urandom, $urandom};

        if (vd) begin
            do_handshake(2'd2, wb_retry, wb_resp);
        end
        do_handshake(2'd1, ld_retry, ld_resp);

        for (int s = 0; s < nstray; s++) begin
            mem_tag = (s == 0) ? first_stray : rand_stray(ld_resp);
            mem_data_in = {$urandom, $urandom};
            req_valid = 1'($urandom_range(0, 1)); cache_miss = 1'b1;
            req_tag = 8'($urandom); req_index = 3'($urandom); req_write = 1'($urandom_range(0, 1));
            step();
        end
        req_valid = 1'b0; cache_miss = 1'b0; mem_tag = 4'd0;

        if (do_reset) begin
            reset = 1'b0;
            #1;
            check_output("rst_busy", 64'(ctrl_busy), 64'd0);
            check_output("rst_cmd", 64'(mem_command), 64'd0);
            check_output("rst_addr", 64'(mem_addr), 64'd0);
            check_output("rst_mdata", mem_data, 64'd0);
            check_output("rst_fill", 64'({fill_valid, fill_tag, fill_index, fill_dirty, resp_valid}), 64'd0);
            check_output("rst_fdata", fill_data | resp_data, 64'd0);
            sb.delete();
            exp_miss = 0;
            exp_wb = 0;
            step();
            reset = 1'b1;
            mem_tag = ld_resp; mem_data_in = line;
            step();
            mem_tag = 4'd0;
            check_output("fill_after_reset", 64'(fill_valid), 64'd0);
            check_output("busy_after_reset", 64'(ctrl_busy), 64'd0);
            step();
            check_output("fill_after_reset2", 64'(fill_valid), 64'd0);
            return;
        end

        mem_tag = ld_resp; mem_data_in = line;
        step();
        mem_tag = 4'd0; mem_data_in = {$urandom, $urandom};
        check_output("fill_latency", 64'(fill_valid), 64'd1);
        check_output("busy_in_fill", 64'(ctrl_busy), 64'd1);
        step();
        check_output("busy_after_fill", 64'(ctrl_busy), 64'd0);
    endtask

    // Idle gap sprinkled with cache hits, which must not start a miss
    task automatic idle_gap(input int n);
        for (int i = 0; i < n; i++) begin
            req_valid = 1'($urandom_range(0, 1)); cache_miss = 1'b0;
            req_tag = 8'($urandom); req_index = 3'($urandom);
            victim_dirty = 1'($urandom_range(0, 1));
            step();
            check_output("idle_busy", 64'(ctrl_busy), 64'd0);
        end
        req_valid = 1'b0; cache_miss = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_tag = '0; req_index = '0; req_data = '0;
        cache_miss = 1'b0; victim_dirty = 1'b0; victim_data = '0; victim_tag = '0; victim_index = '0;
        mem_response = '0; mem_data_in = '0; mem_tag = '0;
        #2;
        check_output("reset_busy", 64'(ctrl_busy), 64'd0);
        check_output("reset_cmd", 64'(mem_command), 64'd0);
        check_output("reset_fill", 64'(fill_valid), 64'd0);
        check_output("reset_resp", 64'(resp_valid), 64'd0);
        step();
        step();
        reset = 1'b1;
        step();

        // Clean load miss
        apply_stimulus(8'h5A, 3'd3, 1'b0, 64'h0, 1'b0, 8'h00, 3'd0, 64'h0,
                       0, 0, 4'd0, 4'h2, 64'hDEADBEEF_CAFEF00D, 2, 4'd0, 1'b0);
        idle_gap(2);
        // Dirty eviction with three retries on the writeback
        apply_stimulus(8'h5A, 3'd3, 1'b0, 64'h0, 1'b1, 8'h11, 3'd3, 64'h1234,
                       3, 0, 4'h5, 4'h6, 64'h0BAD_F00D_0000_1111, 1, 4'd0, 1'b0);
        idle_gap(1);
        // Store miss
        apply_stimulus(8'h22, 3'd5, 1'b1, 64'hAAAA, 1'b0, 8'h00, 3'd0, 64'h0,
                       0, 1, 4'd0, 4'h9, 64'h5555_6666_7777_8888, 1, 4'd0, 1'b0);
        idle_gap(1);
        // Stray tag before the pending one
        apply_stimulus(8'h33, 3'd1, 1'b0, 64'h0, 1'b0, 8'h00, 3'd0, 64'h0,
                       0, 0, 4'd0, 4'h3, 64'h0123_4567_89AB_CDEF, 1, 4'h7, 1'b0);
        idle_gap(1);
        // Reset mid-miss in FILL_WAIT
        apply_stimulus(8'h44, 3'd2, 1'b0, 64'h0, 1'b1, 8'h77, 3'd2, 64'hFEED,
                       1, 1, 4'h4, 4'h8, 64'hCAFE_0000_0000_BEEF, 2, 4'd0, 1'b1);
        idle_gap(2);

        for (int t = 0; t < 40; t++) begin
            logic [3:0] lr;
            lr = 4'($urandom_range(1, 15));
            apply_stimulus(8'($urandom), 3'($urandom), 1'($urandom_range(0, 1)), {$urandom, $urandom},
                           1'($urandom_range(0, 1)), 8'($urandom), 3'($urandom), {$urandom, $urandom},
                           $urandom_range(0, 3), $urandom_range(0, 3), 4'($urandom_range(1, 15)), lr,
                           {$urandom, $urandom}, $urandom_range(0, 4), rand_stray(lr), 1'b0);
            idle_gap($urandom_range(0, 3));
        end

        step();
        check_output("scoreboard_empty", 64'(sb.size()), 64'd0);
`ifdef DCACHE_MISS_STATS_EN
        check_output("miss_count", 64'(miss_count), 64'(exp_miss));
        check_output("wb_count", 64'(wb_count), 64'(exp_wb));
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
